// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the hold-flag encoding, FSM state encoding, zero constants and the
// operand-match helper used by load-use detection.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned HoldFlagBusW = 3;

  typedef logic [HoldFlagBusW-1:0] hold_flag_t;

  // Deeper hold values freeze more of the front end: Pc < If < Id.
  localparam hold_flag_t HoldNone = 3'd0;
  localparam hold_flag_t HoldPc   = 3'd1;
  localparam hold_flag_t HoldIf   = 3'd2;
  localparam hold_flag_t HoldId   = 3'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFlush   = 2'd1,
    StMcWait  = 2'd2,
    StLuStall = 2'd3
  } ctrl_state_e;

  localparam logic [4:0]  ZeroReg  = 5'd0;
  localparam logic [31:0] ZeroWord = 32'd0;

  // A source operand depends on a destination only when it is actually read.
  function automatic logic rs_match(input logic [4:0] rs_addr,
                                    input logic       rs_re,
                                    input logic [4:0] rd_addr);
    return rs_re && (rs_addr == rd_addr);
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   clr_i  - clear to zero; wins over inc_i, the cycle is not counted
//   inc_i  - count one event this cycle
//   cnt_o  - current count, sticks at all-ones
module hazard_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller: generates hold/stall controls for PC, IF/ID
// and ID/EX, the redirect strobe and target, a saturating hazard-cycle
// counter and a sticky multi-cycle timeout flag.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   id_rs{1,2}_raddr_i/_re_i     - source operands of the instruction in ID
//   ex_reg_we_i/_waddr_i         - destination of the instruction in EX
//   ex_is_load_i                 - EX instruction is a load
//   ex_redirect_i/_addr_i        - EX mispredict and its target
//   div_start_i, div_busy_i      - divider handshake
//   clint_hold_i, bus_hold_i     - external hold requests
//   cnt_clr_i                    - clear the hazard counter
//   hold_flag_o, stall_flag_o    - pipeline hold level and ID/EX freeze
//   redirect_o, redirect_addr_o  - PC load strobe and latched target
//   hazard_cnt_o                 - cycles with any hold or stall
//   mc_timeout_err_o             - sticky divider timeout
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MC_TIMEOUT   = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              id_rs1_raddr_i,
  input  logic                    id_rs1_re_i,
  input  logic [4:0]              id_rs2_raddr_i,
  input  logic                    id_rs2_re_i,
  input  logic                    ex_reg_we_i,
  input  logic [4:0]              ex_reg_waddr_i,
  input  logic                    ex_is_load_i,
  input  logic                    ex_redirect_i,
  input  logic [31:0]             ex_redirect_addr_i,
  input  logic                    div_start_i,
  input  logic                    div_busy_i,
  input  logic                    clint_hold_i,
  input  logic                    bus_hold_i,
  input  logic                    cnt_clr_i,
  output logic [HoldFlagBusW-1:0] hold_flag_o,
  output logic                    stall_flag_o,
  output logic                    redirect_o,
  output logic [31:0]             redirect_addr_o,
  output logic [CNT_W-1:0]        hazard_cnt_o,
  output logic                    mc_timeout_err_o
);

  localparam int unsigned TmoW      = $clog2(MC_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MC_TIMEOUT - 1);
  localparam logic [2:0] FlushInit  = 3'(FLUSH_CYCLES - 1);

  ctrl_state_e     state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  // Remembers that a flush interrupted a divide so it can be resumed.
  logic            resume_mc_q, resume_mc_d;
  logic            tmo_err_q;
  logic            tmo_err_set;
  logic [31:0]     redirect_addr_q;

  hold_flag_t      hold;
  logic            stall;
  logic            redirect;
  logic            lu_hit;
  logic            mc_live;

  assign lu_hit = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != ZeroReg) &&
                  (rs_match(id_rs1_raddr_i, id_rs1_re_i, ex_reg_waddr_i) ||
                   rs_match(id_rs2_raddr_i, id_rs2_re_i, ex_reg_waddr_i));

  // Divide still outstanding: either waiting on it now or parked behind a flush.
  assign mc_live = ((state_q == StMcWait) || ((state_q == StFlush) && resume_mc_q)) &&
                   div_busy_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    resume_mc_d = resume_mc_q;
    hold        = HoldNone;
    stall       = 1'b0;
    redirect    = 1'b0;
    tmo_err_set = 1'b0;

    if (ex_redirect_i) begin
      redirect = 1'b1;
      hold     = HoldId;
      if (FLUSH_CYCLES > 1) begin
        state_d     = StFlush;
        flush_cnt_d = FlushInit;
        resume_mc_d = mc_live;
      end else begin
        state_d     = mc_live ? StMcWait : StIdle;
        resume_mc_d = 1'b0;
      end
      // Timeout progress survives a flush only if the divide is still running.
      if (!mc_live) begin
        tmo_cnt_d = '0;
      end
    end else if (state_q == StFlush) begin
      hold        = HoldId;
      flush_cnt_d = flush_cnt_q - 1'b1;
      if (flush_cnt_q <= 3'd1) begin
        state_d     = mc_live ? StMcWait : StIdle;
        resume_mc_d = 1'b0;
        if (!mc_live) begin
          tmo_cnt_d = '0;
        end
      end
    end else begin
      if (clint_hold_i) begin
        hold = HoldId;
      end

      case (state_q)
        StMcWait: begin
          if (!div_busy_i) begin
            state_d   = StIdle;
            tmo_cnt_d = '0;
          end else begin
            hold = HoldId;
            if (tmo_cnt_q == TmoLast) begin
              tmo_err_set = 1'b1;
              state_d     = StIdle;
              tmo_cnt_d   = '0;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
          end
        end
        StIdle: begin
          if (div_start_i) begin
            state_d   = StMcWait;
            tmo_cnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase

      if ((hold == HoldNone) && bus_hold_i) begin
        hold = HoldPc;
      end

      // An Id-level hold already bubbles ID/EX, so a load-use hit is dropped
      // then; LU_STALL itself never re-stalls.
      if (lu_hit && (hold != HoldId) && (state_q != StLuStall) && (state_d == StIdle)) begin
        stall   = 1'b1;
        hold    = HoldIf;
        state_d = StLuStall;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      flush_cnt_q     <= '0;
      tmo_cnt_q       <= '0;
      resume_mc_q     <= 1'b0;
      tmo_err_q       <= 1'b0;
      redirect_addr_q <= ZeroWord;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      resume_mc_q <= resume_mc_d;
      if (tmo_err_set) begin
        tmo_err_q <= 1'b1;
      end
      if (redirect) begin
        redirect_addr_q <= ex_redirect_addr_i;
      end
    end
  end

  // Combinational controls are forced quiet while reset is asserted.
  assign hold_flag_o      = rst ? HoldNone : hold;
  assign stall_flag_o     = rst ? 1'b0 : stall;
  assign redirect_o       = rst ? 1'b0 : redirect;
  assign redirect_addr_o  = redirect_addr_q;
  assign mc_timeout_err_o = tmo_err_q;

  hazard_sat_counter #(
    .Width (CNT_W)
  ) u_hazard_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr_i),
    .inc_i ((hold_flag_o != HoldNone) || stall_flag_o),
    .cnt_o (hazard_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each cycle pushes its expected
// outputs, then pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int unsigned CntW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1_raddr, id_rs2_raddr, ex_reg_waddr;
  logic             id_rs1_re, id_rs2_re, ex_reg_we, ex_is_load;
  logic             ex_redirect;
  logic [31:0]      ex_redirect_addr;
  logic             div_start, div_busy, clint_hold, bus_hold, cnt_clr;
  logic [2:0]       hold_flag;
  logic             stall_flag, redirect;
  logic [31:0]      redirect_addr;
  logic [CntW-1:0]  hazard_cnt;
  logic             mc_timeout_err;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MC_TIMEOUT   (64),
    .CNT_W        (CntW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .id_rs1_raddr_i     (id_rs1_raddr),
    .id_rs1_re_i        (id_rs1_re),
    .id_rs2_raddr_i     (id_rs2_raddr),
    .id_rs2_re_i        (id_rs2_re),
    .ex_reg_we_i        (ex_reg_we),
    .ex_reg_waddr_i     (ex_reg_waddr),
    .ex_is_load_i       (ex_is_load),
    .ex_redirect_i      (ex_redirect),
    .ex_redirect_addr_i (ex_redirect_addr),
    .div_start_i        (div_start),
    .div_busy_i         (div_busy),
    .clint_hold_i       (clint_hold),
    .bus_hold_i         (bus_hold),
    .cnt_clr_i          (cnt_clr),
    .hold_flag_o        (hold_flag),
    .stall_flag_o       (stall_flag),
    .redirect_o         (redirect),
    .redirect_addr_o    (redirect_addr),
    .hazard_cnt_o       (hazard_cnt),
    .mc_timeout_err_o   (mc_timeout_err)
  );

  typedef struct packed {
    logic [2:0]      hold;
    logic            stall;
    logic            redir;
    logic [31:0]     addr;
    logic [CntW-1:0] cnt;
    logic            err;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference state of the registered outputs.
  logic [CntW-1:0] m_cnt  = '0;
  logic            m_err  = 1'b0;
  logic [31:0]     m_addr = '0;

  task automatic idle_inputs();
    id_rs1_raddr = 5'd0; id_rs1_re = 1'b0;
    id_rs2_raddr = 5'd0; id_rs2_re = 1'b0;
    ex_reg_we = 1'b0; ex_reg_waddr = 5'd0; ex_is_load = 1'b0;
    ex_redirect = 1'b0; ex_redirect_addr = 32'd0;
    div_start = 1'b0; div_busy = 1'b0;
    clint_hold = 1'b0; bus_hold = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2);
    ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_reg_waddr = rd;
    id_rs1_raddr = rs1; id_rs1_re = re1;
    id_rs2_raddr = rs2; id_rs2_re = re2;
  endtask

  // Inputs are already driven (just after a negedge); compare, then advance a cycle.
  task automatic cycle(input logic [2:0] h, input logic s, input logic r, input string tag);
    exp_t  e;
    string t;
    e.hold = h; e.stall = s; e.redir = r;
    e.addr = m_addr; e.cnt = m_cnt; e.err = m_err;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    n_vec += 6;
    if (hold_flag !== e.hold) begin
      n_bad++; $display("FAIL %s hold_flag_o got %0d want %0d", t, hold_flag, e.hold);
    end
    if (stall_flag !== e.stall) begin
      n_bad++; $display("FAIL %s stall_flag_o got %0b want %0b", t, stall_flag, e.stall);
    end
    if (redirect !== e.redir) begin
      n_bad++; $display("FAIL %s redirect_o got %0b want %0b", t, redirect, e.redir);
    end
    if (redirect_addr !== e.addr) begin
      n_bad++; $display("FAIL %s redirect_addr_o got %h want %h", t, redirect_addr, e.addr);
    end
    if (hazard_cnt !== e.cnt) begin
      n_bad++; $display("FAIL %s hazard_cnt_o got %0d want %0d", t, hazard_cnt, e.cnt);
    end
    if (mc_timeout_err !== e.err) begin
      n_bad++; $display("FAIL %s mc_timeout_err_o got %0b want %0b", t, mc_timeout_err, e.err);
    end
    // Apply the coming clock edge to the reference state.
    if (rst) begin
      m_cnt = '0; m_err = 1'b0; m_addr = '0;
    end else begin
      if (cnt_clr) m_cnt = '0;
      else if (((h != HoldNone) || s) && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
      if (ex_redirect) m_addr = ex_redirect_addr;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_hold = 1'b1; clint_hold = 1'b1;
    ex_redirect = 1'b1; ex_redirect_addr = 32'hDEAD_BEEF;
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    cycle(HoldNone, 1'b0, 1'b0, "reset_gate");
    rst = 1'b0; idle_inputs();
    cycle(HoldNone, 1'b0, 1'b0, "reset_idle");
  endtask

  task automatic test_load_use();
    set_load(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    cycle(HoldIf, 1'b1, 1'b0, "lu_rs1");
    cycle(HoldNone, 1'b0, 1'b0, "lu_stall_once");
    idle_inputs();
    cycle(HoldNone, 1'b0, 1'b0, "lu_release");
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    cycle(HoldNone, 1'b0, 1'b0, "lu_x0");
    set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    cycle(HoldIf, 1'b1, 1'b0, "lu_rs2");
    idle_inputs();
    cycle(HoldNone, 1'b0, 1'b0, "lu_rs2_after");
    set_load(5'd9, 5'd9, 1'b0, 5'd2, 1'b1);
    cycle(HoldNone, 1'b0, 1'b0, "lu_not_read");
    set_load(5'd9, 5'd9, 1'b1, 5'd2, 1'b1); ex_is_load = 1'b0;
    cycle(HoldNone, 1'b0, 1'b0, "lu_not_load");
    idle_inputs();
  endtask

  task automatic test_bus_clint();
    bus_hold = 1'b1;
    cycle(HoldPc, 1'b0, 1'b0, "bus_alone");
    set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    cycle(HoldIf, 1'b1, 1'b0, "bus_plus_lu");
    cycle(HoldPc, 1'b0, 1'b0, "bus_in_lu_stall");
    idle_inputs(); clint_hold = 1'b1;
    cycle(HoldId, 1'b0, 1'b0, "clint_alone");
    set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    cycle(HoldId, 1'b0, 1'b0, "clint_drops_lu");
    idle_inputs();
    cycle(HoldNone, 1'b0, 1'b0, "clint_release");
  endtask

  task automatic test_redirect();
    ex_redirect = 1'b1; ex_redirect_addr = 32'h0000_0100;
    cycle(HoldId, 1'b0, 1'b1, "redir");
    idle_inputs();
    cycle(HoldId, 1'b0, 1'b0, "redir_flush");
    cycle(HoldNone, 1'b0, 1'b0, "redir_done");
    cycle(HoldNone, 1'b0, 1'b0, "redir_addr_kept");
  endtask

  task automatic test_simultaneous();
    ex_redirect = 1'b1; ex_redirect_addr = 32'h0000_0200; bus_hold = 1'b1;
    set_load(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    cycle(HoldId, 1'b0, 1'b1, "simul_redir");
    ex_redirect = 1'b0;
    cycle(HoldId, 1'b0, 1'b0, "simul_flush");
    idle_inputs();
    cycle(HoldNone, 1'b0, 1'b0, "simul_done");
  endtask

  task automatic test_back_to_back();
    ex_redirect = 1'b1; ex_redirect_addr = 32'h0000_0300;
    cycle(HoldId, 1'b0, 1'b1, "b2b_first");
    ex_redirect_addr = 32'h0000_0400;
    cycle(HoldId, 1'b0, 1'b1, "b2b_second");
    idle_inputs();
    cycle(HoldId, 1'b0, 1'b0, "b2b_flush");
    cycle(HoldNone, 1'b0, 1'b0, "b2b_done");
  endtask

  task automatic test_divider();
    div_start = 1'b1;
    cycle(HoldNone, 1'b0, 1'b0, "div_start");
    div_start = 1'b0; div_busy = 1'b1;
    for (int i = 0; i < 10; i++) cycle(HoldId, 1'b0, 1'b0, "div_busy");
    div_busy = 1'b0;
    cycle(HoldNone, 1'b0, 1'b0, "div_done");
    cycle(HoldNone, 1'b0, 1'b0, "div_idle");
  endtask

  task automatic test_redirect_in_div();
    div_start = 1'b1;
    cycle(HoldNone, 1'b0, 1'b0, "rdiv_start");
    div_start = 1'b0; div_busy = 1'b1;
    for (int i = 0; i < 3; i++) cycle(HoldId, 1'b0, 1'b0, "rdiv_busy");
    ex_redirect = 1'b1; ex_redirect_addr = 32'h0000_0500;
    cycle(HoldId, 1'b0, 1'b1, "rdiv_redir");
    ex_redirect = 1'b0;
    cycle(HoldId, 1'b0, 1'b0, "rdiv_flush");
    cycle(HoldId, 1'b0, 1'b0, "rdiv_resumed");
    div_busy = 1'b0;
    cycle(HoldNone, 1'b0, 1'b0, "rdiv_done");
  endtask

  task automatic test_timeout();
    div_start = 1'b1;
    cycle(HoldNone, 1'b0, 1'b0, "tmo_start");
    div_start = 1'b0; div_busy = 1'b1;
    for (int i = 0; i < 64; i++) cycle(HoldId, 1'b0, 1'b0, "tmo_wait");
    m_err = 1'b1;
    for (int i = 0; i < 36; i++) cycle(HoldNone, 1'b0, 1'b0, "tmo_idle");
    div_busy = 1'b0;
    cycle(HoldNone, 1'b0, 1'b0, "tmo_after");
  endtask

  task automatic test_reset_mid_mc();
    div_start = 1'b1;
    cycle(HoldNone, 1'b0, 1'b0, "rmc_start");
    div_start = 1'b0; div_busy = 1'b1;
    for (int i = 0; i < 5; i++) cycle(HoldId, 1'b0, 1'b0, "rmc_busy");
    rst = 1'b1;
    cycle(HoldNone, 1'b0, 1'b0, "rmc_reset");
    rst = 1'b0;
    cycle(HoldNone, 1'b0, 1'b0, "rmc_post_reset");
    div_busy = 1'b0;
    cycle(HoldNone, 1'b0, 1'b0, "rmc_idle");
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1; bus_hold = 1'b1;
    cycle(HoldPc, 1'b0, 1'b0, "cnt_clr_first");
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) cycle(HoldPc, 1'b0, 1'b0, "cnt_run");
    n_vec++;
    if (hazard_cnt !== 4'hF) begin
      n_bad++; $display("FAIL cnt_saturate hazard_cnt_o got %0d want 15", hazard_cnt);
    end
    cnt_clr = 1'b1;
    cycle(HoldPc, 1'b0, 1'b0, "cnt_clr_in_hold");
    n_vec++;
    if (hazard_cnt !== 4'h0) begin
      n_bad++; $display("FAIL cnt_cleared hazard_cnt_o got %0d want 0", hazard_cnt);
    end
    idle_inputs();
    cycle(HoldNone, 1'b0, 1'b0, "cnt_idle");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_bus_clint();
    test_redirect();
    test_simultaneous();
    test_back_to_back();
    test_divider();
    test_redirect_in_div();
    test_timeout();
    test_reset_mid_mc();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller that drives the hold and stall controls of the PC, IF/ID and ID/EX registers.
- Arbitrates hold sources by priority: branch/jump redirect flush, interrupt hold, multi-cycle (divider) wait, bus hold.
- Detects load-use hazards and issues a one-cycle freeze.
- Guarantees freeze and flush are never requested together.
- Keeps a saturating hazard-cycle counter and a sticky multi-cycle timeout error.

Parameters:
FLUSH_CYCLES, 1, cycles of Hold_Id issued per redirect (1..7)
MC_TIMEOUT, 64, max cycles in MC_WAIT before forced exit with error
CNT_W, 32, width of hazard-cycle counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_rs1_raddr_i  in  5  rs1 address of the instruction in ID
id_rs1_re_i  in  1  rs1 is read
id_rs2_raddr_i  in  5  rs2 address of the instruction in ID
id_rs2_re_i  in  1  rs2 is read
ex_reg_we_i  in  1  EX instruction writes a GPR
ex_reg_waddr_i  in  5  EX destination register
ex_is_load_i  in  1  EX instruction is a load
ex_redirect_i  in  1  EX resolved jump/branch mispredict, redirect needed
ex_redirect_addr_i  in  32  redirect target
div_start_i  in  1  divider accepted an operation this cycle
div_busy_i  in  1  divider busy
clint_hold_i  in  1  interrupt controller requests hold
bus_hold_i  in  1  bus master not granted
cnt_clr_i  in  1  clear hazard counter
hold_flag_o  out  3  Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3
stall_flag_o  out  1  freeze ID/EX and upstream
redirect_o  out  1  load PC with redirect_addr_o
redirect_addr_o  out  32  PC target
hazard_cnt_o  out  CNT_W  cycles with hold_flag_o!=0 or stall_flag_o
mc_timeout_err_o  out  1  sticky multi-cycle timeout flag

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - state IDLE; flush and timeout counters 0.
  - hazard_cnt_o=0; mc_timeout_err_o=0; redirect_addr_o=0.
  - While rst=1, all combinational outputs are 0.
  - Reset mid-FLUSH or mid-MC_WAIT aborts immediately.
- FSM states: IDLE, FLUSH, MC_WAIT, LU_STALL. Outputs are Mealy: combinational from state and inputs, same cycle.
- Priority, evaluated every cycle, highest first:
  - P1 ex_redirect_i: redirect_o=1, hold_flag_o=Hold_Id, latch redirect_addr_o.
    - If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1, else stay/return to the resumed state.
    - A redirect from any state preempts it. From MC_WAIT, return to MC_WAIT after the flush if div_busy_i is still 1.
  - P2 FLUSH: hold_flag_o=Hold_Id; decrement flush_cnt; leave at 0.
  - P3 clint_hold_i: hold_flag_o=Hold_Id. No state change; MC timeout continues to count.
  - P4 MC_WAIT, entered on div_start_i from IDLE: hold_flag_o=Hold_Id while div_busy_i=1.
    - Exit to IDLE in the cycle div_busy_i=0 (hold drops that cycle).
    - tmo_cnt increments each MC_WAIT cycle. When it reaches MC_TIMEOUT: set mc_timeout_err_o (sticky until rst) and go to IDLE.
  - P5 bus_hold_i: hold_flag_o=Hold_Pc.
  - P6 load-use: ex_is_load_i & ex_reg_we_i & ex_reg_waddr_i!=0, and (rs1 match & id_rs1_re_i) or (rs2 match & id_rs2_re_i).
    - Response: stall_flag_o=1, hold_flag_o=Hold_If, go to LU_STALL.
    - LU_STALL lasts exactly one cycle and never re-asserts the stall; next state IDLE.
- Invariant: stall_flag_o=1 only when hold_flag_o<Hold_Id. A load-use hit in the same cycle as P1–P4 is dropped, because the flush bubbles ID/EX anyway.
- redirect_addr_o holds its last latched value between redirects.
- hazard_cnt_o:
  - +1 per cycle with hold_flag_o!=0 or stall_flag_o; saturates at all-ones.
  - cnt_clr_i has priority over increment: the value becomes 0 and that cycle is not counted.

Decomposition:
- Shared package/defines holds:
  - Hold_None, Hold_Pc, Hold_If, Hold_Id and Hold_Flag_Bus width.
  - FSM state encodings.
  - ZeroReg, ZeroWord.
- One natural sub-module: hazard_sat_counter (CNT_W saturating counter with clear), reusable for other perf counters.
- The FSM and priority logic stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 (rs1_re=1) → stall_flag_o=1 and hold_flag_o=2 for exactly 1 cycle, then 0/0. Same case with ex_reg_waddr_i=0 → no stall.
- Redirect with FLUSH_CYCLES=2, addr 0x0000_0100 → redirect_o=1 for 1 cycle; hold_flag_o=3 for 2 cycles; redirect_addr_o=0x100 persists afterwards.
- Divider: div_start_i, busy held 10 cycles → hold_flag_o=3 for 10 cycles, 0 on the cycle busy falls. Busy held 100 cycles with MC_TIMEOUT=64 → mc_timeout_err_o=1 after 64 cycles, state IDLE.
- Simultaneous events:
  - Redirect + load-use + bus_hold in the same cycle → hold_flag_o=3, stall_flag_o=0, redirect_o=1.
  - bus_hold alone → hold_flag_o=1.
- Reset mid-MC_WAIT (rst=1 for 1 cycle) → outputs 0 next cycle, counter 0, error 0.
- Counter: preload near all-ones with CNT_W=4 → saturates at 15. cnt_clr_i during a hold → value 0.
